div_arbiter: RTL and testbench
==============================

Name: div_arbiter

Overview:
- Round-robin scheduler that shares one sequential integer divider among N_REQ requesters (e.g. per-channel centroid and speed computations in the vision/motor pipeline).
- Divider interface: 17-bit dividend, 12-bit divisor, one-cycle `divide` start pulse, one-cycle done pulse, 17-bit quotient/remainder.
- The block captures operands at grant and sequences the divider's one-cycle operand-setup requirement.
- It short-circuits trivial cases, guards against a hung divider with a watchdog, and returns results to the granted requester with a one-cycle done pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W_IDX, 2, width of grant index, = ceil(log2(N_REQ))
- TIMEOUT, 64, max cycles in WAIT before abort (divider worst case is under 40)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester request level
- dividendo  in  N_REQ*17  packed dividends; requester i uses bits [17*i+16:17*i]
- divisor  in  N_REQ*12  packed divisors; requester i uses bits [12*i+11:12*i]
- done  out  N_REQ  one-hot, one-cycle result-valid pulse
- cociente  out  17  shared quotient bus, valid while done != 0
- resto  out  17  shared remainder bus, valid while done != 0
- err  out  1  asserted with done when the result is invalid (divide by zero or timeout)
- busy  out  1  high in every state except IDLE
- gnt_idx  out  W_IDX  index of the current/last granted requester
- div_divide  out  1  start pulse to divider
- div_dividendo  out  17  registered dividend to divider
- div_divisor  out  12  registered divisor to divider
- div_cociente  in  17  divider quotient
- div_resto  in  17  divider remainder
- div_aviso  in  1  divider done pulse

Behaviour:
- Reset (rst=0 at a clk edge, regardless of state):
  - State goes to IDLE.
  - All outputs go to 0 (done, cociente, resto, err, busy, gnt_idx, div_divide, div_dividendo, div_divisor).
  - RR pointer goes to 0; watchdog goes to 0.
  - A divider operation in flight is abandoned. A later div_aviso is ignored outside WAIT.
- States: IDLE, SETUP, START, WAIT, RESP.
- IDLE:
  - If req != 0, grant the first set req bit searching from ptr upward with wrap. Latch that requester's operands into div_dividendo/div_divisor and set gnt_idx.
  - Then ptr <= grant+1 (mod N_REQ).
  - If the latched divisor == 0, go to RESP with cociente=17'h1FFFF, resto=dividend, err=1.
  - Else if the latched dividend == 0, go to RESP with cociente=0, resto=0, err=0.
  - Otherwise go to SETUP.
- SETUP: operands stable on the divider inputs for one cycle; div_divide=0. The divider registers its dividend one cycle before start. Go to START.
- START: div_divide=1 for exactly this cycle; operands held; watchdog cleared. Go to WAIT.
- WAIT:
  - Operands held.
  - On div_aviso=1: capture div_cociente/div_resto, err=0, go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without div_aviso: cociente=0, resto=0, err=1, go to RESP.
  - If div_aviso and the timeout coincide, div_aviso wins.
- RESP: done[gnt_idx]=1 for one cycle, with cociente/resto/err valid; then IDLE.
  - cociente/resto/err hold their values until the next RESP. done and err are checked only while done != 0.
- Latency from grant (IDLE cycle with req):
  - Trivial cases: done at +1.
  - Normal case: done 1 cycle after div_aviso. div_aviso arrives no earlier than 3 cycles after grant.
- Requester contract:
  - Operands are sampled only in the grant cycle, so they may change afterwards.
  - req must drop in the cycle after done. If req is still high when IDLE re-arbitrates, it is a new request.
  - Changes to req while another requester is being served have no effect until IDLE.
- Fairness: a requester waits at most N_REQ-1 complete operations.
- No requests: the block stays in IDLE; div_divide is never asserted.

Test Plan:
- Single request, req[0]: dividend 1000, divisor 7, real divider attached -> div_divide pulses exactly one cycle, 2 cycles after grant, operands stable from SETUP through WAIT; done[0] pulse with cociente=142, resto=6, err=0.
- All four req high from reset release, each with dividend 100*(i+1) and divisor 3, held high until that requester's own done then dropped -> done order 1→2→3→4 (indices 0,1,2,3); results 33r1, 66r2, 100r0, 133r1; then raise req[0] and req[2] together with ptr=0 -> grant 0, then 2.
- req[1] with divisor 0, dividend 555 -> done[1] one cycle after grant, cociente=0x1FFFF, resto=555, err=1, div_divide never asserted.
- req[3] with dividend 0, divisor 9 -> done[3] at grant+1, cociente=0, resto=0, err=0, no div_divide.
- Stub divider that never asserts div_aviso -> done[i] with err=1, cociente=0, exactly TIMEOUT cycles after div_divide. A subsequent late div_aviso in IDLE produces no done.
- rst=0 for one cycle while in WAIT -> all outputs 0 next cycle, state IDLE. A subsequent div_aviso produces no done. A new request is served starting from ptr=0.

Source files
------------

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : div_arbiter
//  Description : Round-robin scheduler sharing one sequential integer divider
//                among N_REQ requesters. Captures operands at grant, gives the
//                divider one operand-setup cycle before the start pulse,
//                short-circuits divide-by-zero and zero dividends, and aborts
//                a hung divider through a watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W_IDX   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*17-1:0]   dividendo,
  input  logic [N_REQ*12-1:0]   divisor,
  output logic [N_REQ-1:0]      done,
  output logic [16:0]           cociente,
  output logic [16:0]           resto,
  output logic                  err,
  output logic                  busy,
  output logic [W_IDX-1:0]      gnt_idx,
  output logic                  div_divide,
  output logic [16:0]           div_dividendo,
  output logic [11:0]           div_divisor,
  input  logic [16:0]           div_cociente,
  input  logic [16:0]           div_resto,
  input  logic                  div_aviso
);

  // Watchdog only has to count up to TIMEOUT-1.
  localparam int W_WD = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [W_IDX-1:0]   ptr_q, ptr_d;
  logic [W_IDX-1:0]   gnt_idx_q, gnt_idx_d;
  logic [W_WD-1:0]    wd_q, wd_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [16:0]        cociente_q, cociente_d;
  logic [16:0]        resto_q, resto_d;
  logic               err_q, err_d;
  logic               div_divide_q, div_divide_d;
  logic [16:0]        div_dividendo_q, div_dividendo_d;
  logic [11:0]        div_divisor_q, div_divisor_d;

  logic               found;
  logic [W_IDX-1:0]   pick;
  logic [16:0]        sel_dvd;
  logic [11:0]        sel_dvs;

  // Index addition modulo N_REQ (N_REQ need not be a power of two).
  function automatic logic [W_IDX-1:0] idx_add(input logic [W_IDX-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return W_IDX'(s);
  endfunction

  // Round-robin search: first active request at or above ptr, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[idx_add(ptr_q, k)]) begin
        found = 1'b1;
        pick  = idx_add(ptr_q, k);
      end
    end
  end

  assign sel_dvd = dividendo[int'(pick)*17 +: 17];
  assign sel_dvs = divisor[int'(pick)*12 +: 12];

  // Next-state and registered-output logic for the grant/divide/respond sequence.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    wd_d            = wd_q;
    done_d          = '0;
    cociente_d      = cociente_q;
    resto_d         = resto_q;
    err_d           = err_q;
    div_divide_d    = 1'b0;
    div_dividendo_d = div_dividendo_q;
    div_divisor_d   = div_divisor_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_idx_d       = pick;
          ptr_d           = idx_add(pick, 1);
          div_dividendo_d = sel_dvd;
          div_divisor_d   = sel_dvs;
          if (sel_dvs == '0) begin
            // Divide by zero: saturated quotient, dividend passed through as remainder.
            cociente_d   = 17'h1FFFF;
            resto_d      = sel_dvd;
            err_d        = 1'b1;
            done_d[pick] = 1'b1;
            state_d      = S_RESP;
          end else if (sel_dvd == '0) begin
            cociente_d   = '0;
            resto_d      = '0;
            err_d        = 1'b0;
            done_d[pick] = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        // Divider latches its dividend this cycle; start pulse follows.
        div_divide_d = 1'b1;
        wd_d         = '0;
        state_d      = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_aviso) begin
          cociente_d          = div_cociente;
          resto_d             = div_resto;
          err_d               = 1'b0;
          done_d[gnt_idx_q]   = 1'b1;
          state_d             = S_RESP;
        end else begin
          wd_d = wd_q + W_WD'(1);
          // Watchdog reaching TIMEOUT-1 puts done exactly TIMEOUT cycles after the start pulse.
          if (wd_q == W_WD'(TIMEOUT - 2)) begin
            cociente_d        = '0;
            resto_d           = '0;
            err_d             = 1'b1;
            done_d[gnt_idx_q] = 1'b1;
            state_d           = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      ptr_q           <= '0;
      gnt_idx_q       <= '0;
      wd_q            <= '0;
      done_q          <= '0;
      cociente_q      <= '0;
      resto_q         <= '0;
      err_q           <= 1'b0;
      div_divide_q    <= 1'b0;
      div_dividendo_q <= '0;
      div_divisor_q   <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      gnt_idx_q       <= gnt_idx_d;
      wd_q            <= wd_d;
      done_q          <= done_d;
      cociente_q      <= cociente_d;
      resto_q         <= resto_d;
      err_q           <= err_d;
      div_divide_q    <= div_divide_d;
      div_dividendo_q <= div_dividendo_d;
      div_divisor_q   <= div_divisor_d;
    end
  end

  assign done          = done_q;
  assign cociente      = cociente_q;
  assign resto         = resto_q;
  assign err           = err_q;
  assign busy          = (state_q != S_IDLE);
  assign gnt_idx       = gnt_idx_q;
  assign div_divide    = div_divide_q;
  assign div_dividendo = div_dividendo_q;
  assign div_divisor   = div_divisor_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_arbiter
//  Description : Directed self-checking bench for div_arbiter with a small
//                behavioural divider (fixed latency, can be made to hang).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

  localparam int N_REQ   = 4;
  localparam int W_IDX   = 2;
  localparam int TIMEOUT = 64;
  localparam int DIV_LAT = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*17-1:0] dividendo;
  logic [N_REQ*12-1:0] divisor;
  logic [N_REQ-1:0]    done;
  logic [16:0]         cociente, resto;
  logic                err, busy;
  logic [W_IDX-1:0]    gnt_idx;
  logic                div_divide;
  logic [16:0]         div_dividendo;
  logic [11:0]         div_divisor;
  logic [16:0]         div_cociente, div_resto;
  logic                div_aviso;

  div_arbiter #(.N_REQ(N_REQ), .W_IDX(W_IDX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .dividendo(dividendo), .divisor(divisor),
    .done(done), .cociente(cociente), .resto(resto), .err(err), .busy(busy),
    .gnt_idx(gnt_idx), .div_divide(div_divide), .div_dividendo(div_dividendo),
    .div_divisor(div_divisor), .div_cociente(div_cociente), .div_resto(div_resto),
    .div_aviso(div_aviso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: answers DIV_LAT+1 cycles after the start pulse unless hung.
  logic        hang   = 1'b0;
  logic        inject = 1'b0;
  logic        m_aviso = 1'b0;
  logic [16:0] m_q = '0, m_r = '0;
  int          m_cnt = 0;
  always @(posedge clk) begin
    m_aviso <= 1'b0;
    if (div_divide) begin
      m_cnt <= DIV_LAT;
      if (div_divisor != '0) begin
        m_q <= 17'(div_dividendo / {5'b0, div_divisor});
        m_r <= 17'(div_dividendo % {5'b0, div_divisor});
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !hang) m_aviso <= 1'b1;
    end
  end
  assign div_aviso    = m_aviso | inject;
  assign div_cociente = m_q;
  assign div_resto    = m_r;

  // Event monitor.
  int n_div = 0, div_cyc = -1, aviso_cyc = -1, n_done = 0;
  always @(negedge clk) begin
    if (div_divide) begin n_div++; div_cyc = cyc; end
    if (div_aviso) aviso_cyc = cyc;
    if (done != '0) n_done++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int dvd, input int dvs);
    dividendo[i*17 +: 17] = 17'(dvd);
    divisor[i*12 +: 12]   = 12'(dvs);
  endtask

  task automatic wait_done(input string tag, input int bound, output int dcyc);
    logic seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done != '0) begin
        seen = 1'b1;
        dcyc = cyc;
        break;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_coc"},   32'(cociente), 32'd0);
    check({tag, "_resto"}, 32'(resto), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_gnt"},   32'(gnt_idx), 32'd0);
    check({tag, "_ddiv"},  32'(div_divide), 32'd0);
    check({tag, "_dvd"},   32'(div_dividendo), 32'd0);
    check({tag, "_dvs"},   32'(div_divisor), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int g, dc, n0, d0, bad;
    int rr_q[4] = '{33, 66, 100, 133};
    int rr_r[4] = '{1, 2, 0, 1};

    rst = 1'b0; req = '0; dividendo = '0; divisor = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    repeat (5) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_divide", 32'(n_div), 32'd0);

    // All four requesters from reset release.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 100 * (i + 1), 3);
    req = 4'hF;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done("rr", 100, dc);
      check("rr_done", 32'(done), 32'(1 << i));
      check("rr_coc", 32'(cociente), 32'(rr_q[i]));
      check("rr_resto", 32'(resto), 32'(rr_r[i]));
      check("rr_err", 32'(err), 32'd0);
      req[i] = 1'b0;
    end

    // Two simultaneous requests with the pointer back at 0.
    set_ops(0, 50, 5);
    set_ops(2, 77, 4);
    req = 4'b0101;
    wait_done("pair0", 100, dc);
    check("pair0_done", 32'(done), 32'h1);
    check("pair0_coc", 32'(cociente), 32'd10);
    check("pair0_resto", 32'(resto), 32'd0);
    req[0] = 1'b0;
    wait_done("pair2", 100, dc);
    check("pair2_done", 32'(done), 32'h4);
    check("pair2_coc", 32'(cociente), 32'd19);
    check("pair2_resto", 32'(resto), 32'd1);
    req[2] = 1'b0;
    tick();

    // Single request 1000/7 with operand latching and start-pulse timing.
    n0 = n_div;
    set_ops(0, 1000, 7);
    req = 4'b0001;
    g = cyc;
    tick();
    set_ops(0, 17'h1ABCD, 0);
    check("sp_setup_nodiv", 32'(div_divide), 32'd0);
    check("sp_setup_dvd", 32'(div_dividendo), 32'd1000);
    check("sp_setup_dvs", 32'(div_divisor), 32'd7);
    tick();
    check("sp_start_div", 32'(div_divide), 32'd1);
    bad = 0;
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done != '0) begin dc = cyc; break; end
      if (div_dividendo !== 17'd1000 || div_divisor !== 12'd7) bad++;
    end
    check("sp_seen", 32'(dc >= 0), 32'd1);
    check("sp_ops_stable", 32'(bad), 32'd0);
    check("sp_div_lat", 32'(div_cyc - g), 32'd2);
    check("sp_div_once", 32'(n_div - n0), 32'd1);
    check("sp_done_after_aviso", 32'(dc - aviso_cyc), 32'd1);
    check("sp_done", 32'(done), 32'h1);
    check("sp_coc", 32'(cociente), 32'd142);
    check("sp_resto", 32'(resto), 32'd6);
    check("sp_err", 32'(err), 32'd0);
    req = '0;
    tick();

    // Divide by zero short-circuit.
    n0 = n_div;
    set_ops(1, 555, 0);
    req = 4'b0010;
    g = cyc;
    wait_done("dz", 10, dc);
    check("dz_lat", 32'(dc - g), 32'd1);
    check("dz_done", 32'(done), 32'h2);
    check("dz_coc", 32'(cociente), 32'h1FFFF);
    check("dz_resto", 32'(resto), 32'd555);
    check("dz_err", 32'(err), 32'd1);
    req = '0;
    tick();
    check("dz_nodiv", 32'(n_div - n0), 32'd0);

    // Zero dividend short-circuit.
    n0 = n_div;
    set_ops(3, 0, 9);
    req = 4'b1000;
    g = cyc;
    wait_done("z0", 10, dc);
    check("z0_lat", 32'(dc - g), 32'd1);
    check("z0_done", 32'(done), 32'h8);
    check("z0_coc", 32'(cociente), 32'd0);
    check("z0_resto", 32'(resto), 32'd0);
    check("z0_err", 32'(err), 32'd0);
    req = '0;
    tick();
    check("z0_nodiv", 32'(n_div - n0), 32'd0);

    // Hung divider: watchdog abort, then a late aviso in IDLE.
    hang = 1'b1;
    set_ops(2, 1234, 5);
    req = 4'b0100;
    wait_done("to", 200, dc);
    check("to_lat", 32'(dc - div_cyc), 32'(TIMEOUT));
    check("to_done", 32'(done), 32'h4);
    check("to_coc", 32'(cociente), 32'd0);
    check("to_resto", 32'(resto), 32'd0);
    check("to_err", 32'(err), 32'd1);
    req = '0;
    d0 = n_done;
    repeat (2) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (4) tick();
    check("to_late_aviso", 32'(n_done - d0), 32'd0);
    check("to_idle", 32'(busy), 32'd0);

    // Reset while waiting on the divider.
    set_ops(1, 90, 9);
    req = 4'b0010;
    repeat (4) tick();
    check("rw_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check_all_zero("rw");
    rst = 1'b1;
    req = '0;
    d0 = n_done;
    repeat (6) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    check("rw_late_aviso", 32'(n_done - d0), 32'd0);
    hang = 1'b0;

    // Pointer restarted at 0: requester 1 wins over 3.
    set_ops(1, 90, 9);
    set_ops(3, 17, 5);
    req = 4'b1010;
    wait_done("rp1", 100, dc);
    check("rp1_done", 32'(done), 32'h2);
    check("rp1_coc", 32'(cociente), 32'd10);
    check("rp1_resto", 32'(resto), 32'd0);
    req[1] = 1'b0;
    wait_done("rp3", 100, dc);
    check("rp3_done", 32'(done), 32'h8);
    check("rp3_coc", 32'(cociente), 32'd3);
    check("rp3_resto", 32'(resto), 32'd2);
    req = '0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
